// File: rtl/lfsr_rng.sv
// lfsr_rng
// ---------------------------------------------------------------------------
// Purpose: Fibonacci-style LFSR pseudo-random source. The state steps on a
// free-running prescaler tick (when enabled), can be reseeded at runtime, is
// protected against the all-zero lock-up state, and offers a request/valid
// draw port that returns a value bounded to [0, range).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         allow the LFSR to step on a prescaler tick
//   seed_load  load seed_in (or SEED when seed_in is zero) this cycle
//   seed_in    seed value, WIDTH bits
//   req        draw request, accepted only while idle
//   range      exclusive upper bound of the draw, OUT_W bits
//   busy       high while a draw is in progress
//   rnd_valid  one-cycle pulse marking a new rnd_out
//   rnd_out    last draw result, held until the next result
//   raw        current LFSR state
// ---------------------------------------------------------------------------
module lfsr_rng #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] TAPS    = 16'hB400,
  parameter logic [WIDTH-1:0] SEED    = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               DIV     = 502500,
  parameter int               OUT_W   = 5,
  parameter int               MAX_TRY = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic [OUT_W-1:0] range,
  output logic             busy,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd_out,
  output logic [WIDTH-1:0] raw
);

  localparam int             PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  LAST    = PW'(DIV - 1);
  localparam int             TW      = $clog2(MAX_TRY + 1);
  localparam logic [TW-1:0]  TRY_MAX = TW'(MAX_TRY);

  typedef enum logic {S_IDLE, S_DRAW} state_t;

  // Smallest all-ones mask covering x: bounds a candidate to below 2*range.
  function automatic logic [OUT_W-1:0] smear(input logic [OUT_W-1:0] x);
    logic [OUT_W-1:0] m;
    m = x;
    for (int i = 1; i < OUT_W; i++) m = m | (m >> i);
    return m;
  endfunction

  state_t           r_fsm;
  logic [PW-1:0]    r_presc;
  logic [WIDTH-1:0] r_lfsr;
  logic [OUT_W-1:0] r_rng;
  logic [OUT_W-1:0] r_mask;
  logic [TW-1:0]    r_try;

  logic             w_tick;
  logic             w_step;
  logic             w_done;
  logic             w_reject;
  logic [OUT_W-1:0] w_cand;
  logic [OUT_W-1:0] w_result;
  logic [WIDTH-1:0] w_nextLfsr;

  assign w_tick = (r_presc == LAST);
  assign w_cand = r_lfsr[OUT_W-1:0] & r_mask;
  assign raw    = r_lfsr;

  // Prescaler runs regardless of en so the tick phase is independent of game state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  // Draw evaluation: a trivially small range yields 0, a fitting candidate is
  // taken as is, and the final attempt folds the candidate back into range.
  always_comb begin
    w_done   = 1'b0;
    w_result = '0;
    if (r_fsm == S_DRAW) begin
      if (r_rng <= OUT_W'(1)) begin
        w_done = 1'b1;
      end else if (w_cand < r_rng) begin
        w_done   = 1'b1;
        w_result = w_cand;
      end else if (r_try >= TRY_MAX) begin
        w_done   = 1'b1;
        w_result = w_cand - r_rng;
      end
    end
  end

  assign w_reject = (r_fsm == S_DRAW) && !w_done;
  assign w_step   = (w_tick && en) || w_reject;

  // Next LFSR state: a load beats a step, and a tick coinciding with a
  // rejection still produces a single step. Zero is never allowed to stick.
  always_comb begin
    w_nextLfsr = r_lfsr;
    if (seed_load)   w_nextLfsr = (seed_in == '0) ? SEED : seed_in;
    else if (w_step) w_nextLfsr = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
    if (w_nextLfsr == '0) w_nextLfsr = SEED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= SEED;
    else        r_lfsr <= w_nextLfsr;
  end

  // Draw FSM with registered busy/rnd_valid/rnd_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm     <= S_IDLE;
      r_rng     <= '0;
      r_mask    <= '0;
      r_try     <= '0;
      busy      <= 1'b0;
      rnd_valid <= 1'b0;
      rnd_out   <= '0;
    end else begin
      rnd_valid <= 1'b0;
      unique case (r_fsm)
        S_IDLE: begin
          if (req) begin
            r_rng  <= range;
            r_mask <= smear(range - OUT_W'(1));
            r_try  <= TW'(1);
            busy   <= 1'b1;
            r_fsm  <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (w_done) begin
            rnd_out   <= w_result;
            rnd_valid <= 1'b1;
            busy      <= 1'b0;
            r_fsm     <= S_IDLE;
          end else begin
            r_try <= r_try + TW'(1);
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lfsr_rng.md
# lfsr_rng

Parametrised pseudo-random source for obstacle generation. It replaces the fixed 5-bit, button-gated generator with a configurable-width LFSR that steps on a prescaled tick. The block also supports runtime seeding, lock-up recovery, and a request/valid draw port that returns a value uniformly bounded to a caller-supplied range. Consumers are the cactus spawner (type/spacing) and any other game logic needing bounded random numbers.

## Interface
- WIDTH, 16, LFSR state width (>= OUT_W, >= 2)
- TAPS, 16'hB400, feedback mask; new bit0 = XOR-reduce(state & TAPS)
- SEED, 1, reset/fallback state (must be non-zero)
- DIV, 502500, prescaler period in clk cycles (>= 1)
- OUT_W, 5, width of range and rnd_out
- MAX_TRY, 8, draw attempts before forced reduction (>= 1)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  allow LFSR to step on prescaler tick (jump button / game running)
- seed_load  in  1  load seed_in into LFSR this cycle
- seed_in  in  WIDTH  seed value
- req  in  1  draw request, accepted only in IDLE
- range  in  OUT_W  exclusive upper bound for draw, sampled on accept
- busy  out  1  high while a draw is in progress
- rnd_valid  out  1  one-cycle pulse, rnd_out holds a new result
- rnd_out  out  OUT_W  last draw result, held until next result
- raw  out  WIDTH  current LFSR state

## Operation
- Step: state <= {state[WIDTH-2:0], ^(state & TAPS)}. Defaults are maximal (period 2^WIDTH-1).
- Prescaler: free-running counter 0..DIV-1, wraps to 0; tick = (count == DIV-1). Runs regardless of en.
- LFSR update priority per cycle: seed_load > step. Step occurs if (tick && en) or a draw rejection; both in one cycle = one step only.
- seed_load with seed_in == 0 loads SEED. Any zero state after update is forced to SEED (lock-up guard).
- Draw FSM: IDLE -> DRAW -> IDLE.
  - IDLE: req high -> latch range into rng_r, mask = OR-smear of (rng_r-1), try count = 1, go DRAW, busy=1.
  - DRAW: cand = state[OUT_W-1:0] & mask.
    - rng_r <= 1: result 0.
    - cand < rng_r: result cand.
    - Reject and try < MAX_TRY: step LFSR, try++, stay.
    - Reject at try == MAX_TRY: result cand - rng_r (mask guarantees cand < 2*rng_r).
    - On result: rnd_out <= result, rnd_valid <= 1, go IDLE, busy <= 0.
- req while busy is ignored (no queueing). seed_load during DRAW is honoured; the draw continues on the new state.
- Reset: state = SEED, prescaler = 0, FSM IDLE, busy = 0, rnd_valid = 0, rnd_out = 0, raw = SEED.

## Timing
- Everything is registered; no combinational input-to-output paths.
- raw reflects a step or load one cycle after the triggering edge.
- req accepted at edge N -> first attempt evaluated in cycle N+1. Acceptance at attempt k gives rnd_valid high during cycle N+k+1, so minimum latency is 2. Maximum latency is MAX_TRY+1.
- rnd_valid is high exactly one cycle. A req in that same cycle is accepted (FSM already IDLE).
- Power-of-two range never rejects: latency is always 2.
- Asynchronous reset mid-draw aborts the draw immediately. No rnd_valid is produced for it.

## Test plan
- Reset: assert rst_n=0 mid-draw -> busy=0, rnd_valid=0, rnd_out=0, raw=SEED immediately. After release, prescaler restarts from 0.
- WIDTH=5, TAPS=5'h12, SEED=1, DIV=4, en=1 -> raw steps every 4 cycles: 00001, 00010, 00101, 01010, 10101, 01011, … Sequence returns to 00001 after exactly 31 steps. With en=0, raw is frozen.
- seed_load with seed_in=0 -> raw=SEED next cycle. seed_load coincident with tick -> loaded value wins, no step.
- Defaults, range=8, req pulse -> rnd_valid exactly 2 cycles later with rnd_out=raw[2:0] at the attempt cycle. range=0 and range=1 -> rnd_out=0 at latency 2.
- Draw with range=5 (mask 7) and MAX_TRY=1, candidate 6 -> rnd_out=1 at latency 2. With MAX_TRY=8, rejections step raw each cycle. Over 10k draws, every result is < 5, latency is <= 9, and value histogram is flat within 5%.
- req held high continuously -> back-to-back draws, one rnd_valid per draw. Any req asserted while busy produces no extra result.
